// File: rtl/counter_seq_ctrl.sv
// Run controller for a 0..999 up-counter: start/stop/clear, prescaled enable, terminal value.
// Optional CNT_SEQ_CTRL_IRQ_EN adds a sticky irq output with irq_ack.
module counter_seq_ctrl #(
  parameter int PRESC_DIV = 1,
  parameter int CNT_MAX   = 999,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              reload,
  input  logic [9:0]        limit,
  input  logic [9:0]        count,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              running,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
`ifdef CNT_SEQ_CTRL_IRQ_EN
  ,
  input  logic              irq_ack,
  output logic              irq
`endif
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC_DIV - 1);
  localparam logic [9:0] CMAX = 10'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [9:0]    lim_eff;
  logic          tick;
  logic          term;
  logic          fire;

  assign lim_eff = (limit > CMAX) ? CMAX : limit;
  assign tick    = (state == RUN) && (presc == PLAST);
  // '>=' so a limit lowered below the current count still terminates
  assign term    = (count >= lim_eff);
  assign fire    = tick && !stop && !clear;

  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (!reset_n || clear) begin
      cnt_clr = 1'b1;
    end else if (fire) begin
      if (!term) cnt_en = 1'b1;
      else       cnt_clr = reload;
    end else if (state == DONE && start) begin
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        presc    <= '0;
        running  <= 1'b0;
        wrap_cnt <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          PAUSE: begin
            if (!stop && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              if (tick && term) begin
                done <= 1'b1;
                if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
                if (!reload) begin
                  state   <= DONE;
                  running <= 1'b0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CNT_SEQ_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n || clear) irq <= 1'b0;
    else if (done)         irq <= 1'b1;
    else if (irq_ack)      irq <= 1'b0;
  end
`endif

endmodule
